seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle 32-bit shift unit for the MIPS datapath; complements the fixed left-by-2 branch-offset shifter.
- Executes SRL, SRA and SLL by a variable amount, shifting one bit position per clock.
- Sits beside the ALU and is driven by the control unit for shift-class instructions.
- Uses a start/busy/done handshake so the control FSM stalls until the result is valid.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when the unit is ready (IDLE or DONE)
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved (executes as SRL)
- data_in  input  WIDTH  operand; latched on an accepted start
- shamt  input  SHAMT_W  shift count; latched on an accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; result valid in the same cycle
- result  output  WIDTH  shifted value; held until the next accepted start

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, busy=0, done=0, result=0, internal count=0 and op_q=0. Reset mid-operation abandons the operation; no done is produced.
- FSM states:
  - IDLE: on start=1, latch data_in into result, latch op into op_q and shamt into count. If shamt==0, go to DONE; otherwise go to SHIFT.
  - SHIFT: busy=1. Each cycle, shift result by one bit and decrement count. When count==1 in the current cycle, the last shift occurs and the next state is DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. If start=1 in DONE, accept it exactly as in IDLE (back-to-back issue, no bubble). Otherwise go to IDLE.
- Shift step by op_q:
  - SLL: result <= {result[WIDTH-2:0], 1'b0}.
  - SRL: result <= {1'b0, result[WIDTH-1:1]}.
  - SRA: result <= {result[WIDTH-1], result[WIDTH-1:1]}, so the sign bit replicates.
- Latency: the start edge is cycle 0. done asserts on cycle shamt+1 (shamt=0 gives 1; shamt=31 gives 32).
- start while in SHIFT is ignored, with no queueing. data_in, op and shamt may change freely after acceptance.
- result does not change in IDLE or DONE except when a new start is accepted. During SHIFT it shows intermediate values; consumers use it only when done=1.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset: rst_n=0 with random inputs -> busy=0, done=0, result=0x00000000. Release, hold start=0 for 10 cycles -> outputs remain unchanged.
- SRA sign fill: op=10, data_in=0x80000000, shamt=4 -> busy=1 for cycles 1-4; done pulses at cycle 5 with result=0xF8000000. Repeating with op=01 -> result=0x08000000.
- SLL maximum count: op=00, data_in=0x00000001, shamt=31 -> done at cycle 32 with result=0x80000000. Pulse width is exactly 1 cycle.
- Zero shift and reserved op: op=11, data_in=0xDEADBEEF, shamt=0 -> done at cycle 1, busy never asserts, result=0xDEADBEEF.
- Busy collision and back-to-back issue:
  - op=01, data_in=0x000000F0, shamt=4; pulse start=1 with data 0xFFFFFFFF at cycle 2 -> ignored; done at cycle 5 with result=0x0000000F.
  - start=1 during that done cycle with op=00, data_in=0x1, shamt=2 -> done 3 cycles later with result=0x00000004.
- Reset mid-operation: op=10, data_in=0x80000000, shamt=20; assert rst_n=0 at cycle 7 -> result=0 and busy=0 immediately, with no done pulse afterward. A new start after release completes normally.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle 32-bit shifter (SLL/SRL/SRA). It shifts one bit per clock and uses a
// start/busy/done handshake so the control FSM can stall until the result is valid.
module seq_shifter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   shifted;

   // Single-bit step. The reserved encoding behaves like SRL.
   always_comb begin
      case (op_q)
         2'b00:   shifted = {result_q[WIDTH-2:0], 1'b0};
         2'b10:   shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
         default: shifted = {1'b0, result_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      op_d     = op_q;
      result_d = result_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               result_d = data_in;
               op_d     = op;
               count_d  = shamt;
               state_d  = (shamt == '0) ? StDone : StShift;
            end else begin
               state_d = StIdle;
            end
         end
         StShift: begin
            result_d = shifted;
            count_d  = count_q - SHAMT_W'(1);
            if (count_q == SHAMT_W'(1)) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
      // Flags are decoded from the next state so that they come straight out of flops.
      busy_d = (state_d == StShift);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         count_q  <= '0;
         op_q     <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter. Each step carries a hand-computed expectation that is
// checked with an immediate assertion.
module tb_seq_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;
   int done_cyc, busy_cnt, busy_first, busy_last, pulses;

   seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .data_in (data_in),
      .shamt   (shamt),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The accepting posedge is cycle 0. The task returns 1 ns after that edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
      @(negedge clk);
      op = o; data_in = d; shamt = s; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // The negedge that follows edge i-1 is cycle i. The task stops on the negedge that sees done.
   task automatic run(input int maxc, output int dc, output int bc, output int bf,
                      output int bl);
      dc = 0; bc = 0; bf = 0; bl = 0;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge clk);
         if (busy) begin
            bc++;
            if (bf == 0) bf = i;
            bl = i;
         end
         if (done) begin
            dc = i;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; op = 2'($urandom); data_in = $urandom;
      shamt = 5'($urandom);

      // Reset, with random inputs present on the pins
      repeat (2) @(negedge clk);
      check("rst_state", {31'd0, busy, done, result}, 64'd0);
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_hold", {31'd0, busy, done, result}, 64'd0);
      end

      // SRA sign fill
      issue(2'b10, 32'h8000_0000, 5'd4);
      run(40, done_cyc, busy_cnt, busy_first, busy_last);
      check("sra_done_cyc", 64'(done_cyc), 64'd5);
      check("sra_busy_span", {32'(busy_first), 32'(busy_last)}, {32'd1, 32'd4});
      check("sra_result", 64'(result), 64'hF800_0000);
      check("sra_busy_at_done", 64'(busy), 64'd0);
      @(negedge clk);
      check("sra_pulse_end", 64'(done), 64'd0);

      // The same operand with SRL
      issue(2'b01, 32'h8000_0000, 5'd4);
      run(40, done_cyc, busy_cnt, busy_first, busy_last);
      check("srl_done_cyc", 64'(done_cyc), 64'd5);
      check("srl_result", 64'(result), 64'h0800_0000);

      // SLL with the largest count
      issue(2'b00, 32'h0000_0001, 5'd31);
      run(60, done_cyc, busy_cnt, busy_first, busy_last);
      check("sll31_done_cyc", 64'(done_cyc), 64'd32);
      check("sll31_busy_cnt", 64'(busy_cnt), 64'd31);
      check("sll31_result", 64'(result), 64'h8000_0000);
      @(negedge clk);
      check("sll31_pulse_end", 64'(done), 64'd0);
      check("sll31_result_held", 64'(result), 64'h8000_0000);

      // Zero shift using the reserved op
      issue(2'b11, 32'hDEAD_BEEF, 5'd0);
      run(10, done_cyc, busy_cnt, busy_first, busy_last);
      check("zero_done_cyc", 64'(done_cyc), 64'd1);
      check("zero_busy_cnt", 64'(busy_cnt), 64'd0);
      check("zero_result", 64'(result), 64'hDEAD_BEEF);

      // A start pulse during SHIFT is ignored
      issue(2'b01, 32'h0000_00F0, 5'd4);
      @(negedge clk);
      check("coll_busy_c1", 64'(busy), 64'd1);
      start = 1'b1; op = 2'b00; data_in = 32'hFFFF_FFFF; shamt = 5'd1;
      @(negedge clk);
      start = 1'b0;
      run(40, done_cyc, busy_cnt, busy_first, busy_last);
      check("coll_done_cyc", 64'(done_cyc + 2), 64'd5);
      check("coll_result", 64'(result), 64'h0000_000F);

      // Back-to-back issue while done is high
      op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b_busy_c1", 64'(busy), 64'd1);
      run(20, done_cyc, busy_cnt, busy_first, busy_last);
      check("b2b_done_cyc", 64'(done_cyc), 64'd3);
      check("b2b_result", 64'(result), 64'h0000_0004);

      // Reset in the middle of an operation
      issue(2'b10, 32'h8000_0000, 5'd20);
      repeat (7) @(negedge clk);
      check("mid_intermediate", 64'(result), 64'hFE00_0000);
      rst_n = 1'b0;
      #1;
      check("mid_rst_now", {31'd0, busy, done, result}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check("mid_no_done", 64'(pulses), 64'd0);
      issue(2'b01, 32'h1234_5678, 5'd8);
      run(20, done_cyc, busy_cnt, busy_first, busy_last);
      check("post_rst_done_cyc", 64'(done_cyc), 64'd9);
      check("post_rst_result", 64'(result), 64'h0012_3456);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
